bbox_scanner: RTL and testbench

Parametrised bounding-box engine for the image-processing path. On a start pulse it streams every pixel of a row-major WxH image from a synchronous-read frame memory. It compares each pixel against a run-time threshold and reports the tightest enclosing box plus the hit-pixel count. It supersedes the fixed 100x100, 8-bit, hard-threshold box finder with configurable geometry, pixel depth, memory latency and compare mode.

---
 rtl/bbox_pkg.sv | 30 +++
 rtl/bbox_accum.sv | 73 +++++++
 rtl/bbox_scanner.sv | 177 +++++++++++++++++
 tb/tb_bbox_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared types and width helpers for the bounding-box scanner.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bbox_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int addr_w(input int w, input int h);
    return clog2_min1(w * h);
  endfunction

  function automatic int coord_w(input int w, input int h);
    return clog2_min1((w > h) ? w : h);
  endfunction

  function automatic int cnt_w(input int w, input int h);
    return clog2_min1(w * h + 1);
  endfunction

  // Drain counter runs 0..lat-1.
  function automatic int drain_w(input int lat);
    return clog2_min1(lat);
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// Running min/max box and hit counter over tagged pixel samples.
// Latency: outputs reflect the sample presented this cycle (combinational over stored state).
// Backpressure: none; accepts one sample per cycle unconditionally.
module bbox_accum import bbox_pkg::*; #(
  parameter int COORD_W = 7,
  parameter int CNT_W   = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               valid,
  input  logic               hit,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   count,
  output logic               any_hit
);

  logic [COORD_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
  logic [CNT_W-1:0]   count_q;
  logic               any_q;

  // Fold the current sample into the stored box; exposing this lets the top
  // capture the final box on the same edge the last sample arrives.
  always_comb begin
    x_min   = x_min_q;
    x_max   = x_max_q;
    y_min   = y_min_q;
    y_max   = y_max_q;
    count   = count_q;
    any_hit = any_q;
    if (valid && hit) begin
      if (!any_q) begin
        // First hit seeds all four edges of the box.
        x_min = x;
        x_max = x;
        y_min = y;
        y_max = y;
      end else begin
        if (x < x_min_q) x_min = x;
        if (x > x_max_q) x_max = x;
        if (y < y_min_q) y_min = y;
        if (y > y_max_q) y_max = y;
      end
      count   = count_q + CNT_W'(1);
      any_hit = 1'b1;
    end
  end

  // Store the running state; clear zeroes it so an empty scan reports a zero box.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
    end else begin
      x_min_q <= x_min;
      x_max_q <= x_max;
      y_min_q <= y_min;
      y_max_q <= y_max;
      count_q <= count;
      any_q   <= any_hit;
    end
  end

endmodule

// File: rtl/bbox_scanner.sv
// Scans a WxH frame memory and reports the thresholded bounding box and hit count.
// Latency: start to done is IMG_W*IMG_H + RD_LAT + 1 cycles.
// Backpressure: none; start is ignored (not queued) while busy.
module bbox_scanner import bbox_pkg::*; #(
  parameter int IMG_W   = 100,
  parameter int IMG_H   = 100,
  parameter int PIX_W   = 8,
  parameter int RD_LAT  = 1,
  parameter int ADDR_W  = addr_w(IMG_W, IMG_H),
  parameter int COORD_W = coord_w(IMG_W, IMG_H),
  parameter int CNT_W   = cnt_w(IMG_W, IMG_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PIX_W-1:0]   threshold,
  input  logic               cmp_mode,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   hit_count,
  output logic               box_valid
);

  localparam int DRAIN_W = drain_w(RD_LAT);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_X     = COORD_W'(IMG_W - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

  state_t             state;
  logic [PIX_W-1:0]   thr_q;
  logic               mode_q;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  // Coordinate tags travel alongside the memory read so each returned pixel
  // meets the (x,y) it was fetched from.
  logic               tag_vld [RD_LAT];
  logic [COORD_W-1:0] tag_x   [RD_LAT];
  logic [COORD_W-1:0] tag_y   [RD_LAT];

  logic               accept, last_drain, smp_hit;
  logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [CNT_W-1:0]   acc_count;
  logic               acc_any;

  assign accept     = (state == IDLE) && start;
  assign last_drain = (state == DRAIN) && (drain_cnt == LAST_DRAIN);
  assign smp_hit    = mode_q ? (rd_data < thr_q) : (rd_data >= thr_q);

  // Control FSM with address/coordinate counters; x/y advance in step with
  // rd_addr so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      drain_cnt <= '0;
      thr_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            thr_q   <= threshold;
            mode_q  <= cmp_mode;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (x_cnt == LAST_X) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + COORD_W'(1);
            end else begin
              x_cnt <= x_cnt + COORD_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline, RD_LAT deep; reset flushes any in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_x[i]   <= '0;
        tag_y[i]   <= '0;
      end
    end else begin
      tag_vld[0] <= rd_en;
      tag_x[0]   <= x_cnt;
      tag_y[0]   <= y_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_x[i]   <= tag_x[i-1];
        tag_y[i]   <= tag_y[i-1];
      end
    end
  end

  bbox_accum #(
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .valid   (tag_vld[RD_LAT-1]),
    .hit     (smp_hit),
    .x       (tag_x[RD_LAT-1]),
    .y       (tag_y[RD_LAT-1]),
    .x_min   (acc_x_min),
    .x_max   (acc_x_max),
    .y_min   (acc_y_min),
    .y_max   (acc_y_max),
    .count   (acc_count),
    .any_hit (acc_any)
  );

  // Result registers load once per scan, on the edge that accumulates the last
  // sample, so they are valid alongside done and hold until the next done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      hit_count <= '0;
      box_valid <= 1'b0;
    end else if (last_drain) begin
      x_min     <= acc_x_min;
      x_max     <= acc_x_max;
      y_min     <= acc_y_min;
      y_max     <= acc_y_max;
      hit_count <= acc_count;
      box_valid <= acc_any;
    end
  end

endmodule

// File: tb/tb_bbox_scanner.sv
// Bench: two scanners (read latency 1 and 3) on one 8x4 image, checked against a
// reference box computed directly from the pixel array.
module tb_bbox_scanner;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int PW = 8;
  localparam int AW = 5;
  localparam int CW = 3;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] threshold = '0;
  logic          cmp_mode = 1'b0;

  logic [1:0]    busy, done, rd_en, box_valid;
  logic [AW-1:0] rd_addr   [2];
  logic [PW-1:0] rd_data   [2];
  logic [CW-1:0] x_min     [2];
  logic [CW-1:0] x_max     [2];
  logic [CW-1:0] y_min     [2];
  logic [CW-1:0] y_max     [2];
  logic [NW-1:0] hit_count [2];

  logic [PW-1:0] img [N];
  logic [PW-1:0] m1_q;
  logic [PW-1:0] m3_q [3];

  int checks = 0;
  int errors = 0;
  int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_vld;
  int p_xmin = 0, p_xmax = 0, p_ymin = 0, p_ymax = 0, p_cnt = 0, p_vld = 0;

  always #5 clk = ~clk;

  bbox_scanner #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold), .cmp_mode(cmp_mode),
    .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .x_min(x_min[0]), .x_max(x_max[0]), .y_min(y_min[0]),
    .y_max(y_max[0]), .hit_count(hit_count[0]), .box_valid(box_valid[0])
  );

  bbox_scanner #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold), .cmp_mode(cmp_mode),
    .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .x_min(x_min[1]), .x_max(x_max[1]), .y_min(y_min[1]),
    .y_max(y_max[1]), .hit_count(hit_count[1]), .box_valid(box_valid[1])
  );

  // Frame memories; data is junk whenever no read was issued.
  always @(posedge clk) begin
    m1_q    <= rd_en[0] ? img[rd_addr[0]] : PW'($urandom);
    m3_q[0] <= rd_en[1] ? img[rd_addr[1]] : PW'($urandom);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rd_data[0] = m1_q;
  assign rd_data[1] = m3_q[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int d, input int xmn, input int xmx,
                           input int ymn, input int ymx, input int cnt, input int vld);
    string t;
    t = $sformatf("%s d%0d", tag, d);
    check({t, " x_min"}, 32'(x_min[d]), 32'(xmn));
    check({t, " x_max"}, 32'(x_max[d]), 32'(xmx));
    check({t, " y_min"}, 32'(y_min[d]), 32'(ymn));
    check({t, " y_max"}, 32'(y_max[d]), 32'(ymx));
    check({t, " hit_count"}, 32'(hit_count[d]), 32'(cnt));
    check({t, " box_valid"}, 32'(box_valid[d]), 32'(vld));
  endtask

  task automatic check_idle_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'd0);
      check($sformatf("%s d%0d done", tag, d), 32'(done[d]), 32'd0);
      check($sformatf("%s d%0d rd_en", tag, d), 32'(rd_en[d]), 32'd0);
      check($sformatf("%s d%0d rd_addr", tag, d), 32'(rd_addr[d]), 32'd0);
      check_res(tag, d, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Reference: scan the whole image as (x,y) coordinates and bound the hits.
  task automatic model(input logic [PW-1:0] thr, input logic mode);
    int cnt = 0;
    int x0 = 0, x1 = 0, y0 = 0, y1 = 0;
    for (int a = 0; a < N; a++) begin
      int x;
      int y;
      bit hit;
      x = a % W;
      y = a / W;
      hit = mode ? (img[a] < thr) : (img[a] >= thr);
      if (hit) begin
        if (cnt == 0) begin
          x0 = x; x1 = x; y0 = y; y1 = y;
        end else begin
          if (x < x0) x0 = x;
          if (x > x1) x1 = x;
          if (y < y0) y0 = y;
          if (y > y1) y1 = y;
        end
        cnt++;
      end
    end
    e_xmin = x0; e_xmax = x1; e_ymin = y0; e_ymax = y1; e_cnt = cnt;
    e_vld = (cnt > 0) ? 1 : 0;
  endtask

  task automatic fill(input logic [PW-1:0] v);
    for (int a = 0; a < N; a++) img[a] = v;
  endtask

  task automatic random_img(input int r, output logic [PW-1:0] thr, output logic mode);
    if (r % 2 == 0) begin
      fill('0);
      for (int i = 0; i < 1 + int'($urandom_range(0, 3)); i++)
        img[$urandom_range(0, N - 1)] = PW'($urandom_range(100, 255));
      thr  = PW'($urandom_range(1, 99));
      mode = 1'b0;
    end else begin
      for (int a = 0; a < N; a++) img[a] = PW'($urandom);
      thr  = PW'($urandom);
      mode = 1'($urandom);
    end
  endtask

  // One scan on both DUTs. restart_at: cycle after start at which a second start
  // is pulsed; reset_at: cycle at which reset is asserted (negative = never).
  task automatic run_scan(input string name, input logic [PW-1:0] thr, input logic mode,
                          input int restart_at, input int reset_at);
    int done_k [2];
    int ndone [2];
    int nrd [2];
    int addr_err [2];
    int exp_addr [2];
    logic busy_at_done [2];
    logic busy_after [2];
    int last_k;
    for (int d = 0; d < 2; d++) begin
      done_k[d] = -10; ndone[d] = 0; nrd[d] = 0; addr_err[d] = 0; exp_addr[d] = 0;
      busy_at_done[d] = 1'b0; busy_after[d] = 1'b1;
    end
    model(thr, mode);
    @(negedge clk);
    start = 1'b1; threshold = thr; cmp_mode = mode;
    @(negedge clk);
    start = 1'b0; threshold = PW'($urandom); cmp_mode = 1'($urandom);
    check({name, " busy first cycle"}, 32'(busy), 32'h3);
    check({name, " rd_en first cycle"}, 32'(rd_en), 32'h3);
    last_k = N + 10;
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d]) begin
          if (32'(rd_addr[d]) != 32'(exp_addr[d])) addr_err[d]++;
          exp_addr[d]++;
          nrd[d]++;
        end
        if (done[d]) begin
          ndone[d]++;
          done_k[d] = k;
          busy_at_done[d] = busy[d];
        end
        if (k == done_k[d] + 1) busy_after[d] = busy[d];
      end
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
      if (restart_at > 0 && k == 20)
        for (int d = 0; d < 2; d++)
          check_res({name, " hold"}, d, p_xmin, p_xmax, p_ymin, p_ymax, p_cnt, p_vld);
      if (k == reset_at) rst_n = 1'b0;
      if (reset_at > 0 && k == reset_at + 1) begin
        check_idle_zero({name, " after reset"});
        rst_n = 1'b1;
        last_k = k + 8;
      end
    end
    if (reset_at > 0) begin
      for (int d = 0; d < 2; d++)
        check($sformatf("%s d%0d no done", name, d), 32'(ndone[d]), 32'd0);
      p_xmin = 0; p_xmax = 0; p_ymin = 0; p_ymax = 0; p_cnt = 0; p_vld = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        int lat;
        lat = (d == 0) ? 1 : 3;
        check($sformatf("%s d%0d done count", name, d), 32'(ndone[d]), 32'd1);
        check($sformatf("%s d%0d done cycle", name, d), 32'(done_k[d]), 32'(N + lat + 1));
        check($sformatf("%s d%0d reads", name, d), 32'(nrd[d]), 32'(N));
        check($sformatf("%s d%0d addr order", name, d), 32'(addr_err[d]), 32'd0);
        check($sformatf("%s d%0d busy at done", name, d), 32'(busy_at_done[d]), 32'd1);
        check($sformatf("%s d%0d busy after done", name, d), 32'(busy_after[d]), 32'd0);
        check_res(name, d, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_vld);
      end
      p_xmin = e_xmin; p_xmax = e_xmax; p_ymin = e_ymin; p_ymax = e_ymax;
      p_cnt = e_cnt; p_vld = e_vld;
    end
  endtask

  initial begin
    logic [PW-1:0] thr;
    logic          mode;
    fill('0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset state");
    rst_n = 1'b1;
    @(negedge clk);

    fill('0); img[2*W + 3] = 8'd9;
    run_scan("single", 8'd5, 1'b0, -1, -1);

    fill(8'd4); img[0] = 8'd9; img[N-1] = 8'd9;
    run_scan("corners", 8'd5, 1'b0, -1, -1);

    fill('0);
    run_scan("empty", 8'd5, 1'b0, -1, -1);
    run_scan("inverted", 8'd5, 1'b1, -1, -1);

    fill('0); img[N-1] = 8'd9;
    run_scan("last pixel", 8'd5, 1'b0, -1, -1);

    random_img(0, thr, mode);
    run_scan("restart ignored", thr, mode, 10, -1);

    random_img(1, thr, mode);
    run_scan("mid reset", thr, mode, -1, 15);

    random_img(2, thr, mode);
    run_scan("fresh", thr, mode, -1, -1);

    for (int r = 0; r < 6; r++) begin
      random_img(r, thr, mode);
      run_scan($sformatf("random%0d", r), thr, mode, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
